// File: rtl/mmu_xlate_pkg.sv
// Shared types for the address translation path: TLB search result, exception codes,
// request op encodings and DMW CSR field positions.
package mmu_xlate_pkg;

    localparam int XLATE_TLBNUM = 16;
    localparam int XLATE_IDXW   = $clog2(XLATE_TLBNUM);

    localparam logic [1:0] XLATE_OP_FETCH = 2'd0;
    localparam logic [1:0] XLATE_OP_LOAD  = 2'd1;
    localparam logic [1:0] XLATE_OP_STORE = 2'd2;

    localparam int DMW_PLV0_BIT = 0;
    localparam int DMW_PLV3_BIT = 3;
    localparam int DMW_MAT_LO   = 4;
    localparam int DMW_PSEG_LO  = 25;
    localparam int DMW_VSEG_LO  = 29;

    typedef enum logic [2:0] {
        EXC_NONE = 3'd0,
        EXC_TLBR = 3'd1,
        EXC_PIL  = 3'd2,
        EXC_PIS  = 3'd3,
        EXC_PIF  = 3'd4,
        EXC_PME  = 3'd5,
        EXC_PPI  = 3'd6
    } xlate_exc_t;

    typedef struct packed {
        logic                  found;
        logic [XLATE_IDXW-1:0] index;
        logic [19:0]           ppn;
        logic [5:0]            ps;
        logic [1:0]            plv;
        logic [1:0]            mat;
        logic                  d;
        logic                  v;
    } tlb_result_t;

    typedef struct packed {
        logic        e;
        logic [9:0]  asid;
        logic        g;
        logic [5:0]  ps;
        logic [18:0] vppn;
        logic [19:0] ppn0;
        logic [1:0]  plv0;
        logic [1:0]  mat0;
        logic        d0;
        logic        v0;
        logic [19:0] ppn1;
        logic [1:0]  plv1;
        logic [1:0]  mat1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    // Invalid-page exception flavour depends on the access kind; op 3 behaves as a load.
    function automatic xlate_exc_t invalid_page_exc(input logic [1:0] op);
        case (op)
            XLATE_OP_FETCH: invalid_page_exc = EXC_PIF;
            XLATE_OP_STORE: invalid_page_exc = EXC_PIS;
            default:        invalid_page_exc = EXC_PIL;
        endcase
    endfunction

endpackage

// File: rtl/mmu_xlate_if.sv
// Request / TLB-search / response bundle of the translation unit.
// slave is the translation unit's view, master is the surrounding pipeline + TLB.
interface mmu_xlate_if
    import mmu_xlate_pkg::*;
#(
    parameter int PALEN = 32,
    parameter int IDXW  = XLATE_IDXW
);
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_va;
    logic [1:0]        req_op;
    logic [1:0]        csr_plv;
    logic              csr_da;
    logic [1:0]        csr_da_mat;
    logic [9:0]        csr_asid;
    logic [31:0]       csr_dmw0;
    logic [31:0]       csr_dmw1;
    logic              tlb_s_valid;
    logic [18:0]       tlb_s_vppn;
    logic              tlb_s_va_bit12;
    logic [9:0]        tlb_s_asid;
    tlb_result_t       tlb_s_result;
    logic              flush;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [PALEN-1:0]  rsp_pa;
    logic [1:0]        rsp_mat;
    xlate_exc_t        rsp_exc;
    logic [IDXW-1:0]   rsp_tlb_index;

    modport slave (
        input  req_valid, req_va, req_op, csr_plv, csr_da, csr_da_mat, csr_asid,
               csr_dmw0, csr_dmw1, tlb_s_result, flush, rsp_ready,
        output req_ready, tlb_s_valid, tlb_s_vppn, tlb_s_va_bit12, tlb_s_asid,
               rsp_valid, rsp_pa, rsp_mat, rsp_exc, rsp_tlb_index
    );

    modport master (
        output req_valid, req_va, req_op, csr_plv, csr_da, csr_da_mat, csr_asid,
               csr_dmw0, csr_dmw1, tlb_s_result, flush, rsp_ready,
        input  req_ready, tlb_s_valid, tlb_s_vppn, tlb_s_va_bit12, tlb_s_asid,
               rsp_valid, rsp_pa, rsp_mat, rsp_exc, rsp_tlb_index
    );
endinterface

// File: rtl/mmu_xlate_dmw_match.sv
// Direct-mapped window decode for one DMW CSR: hit, physical address and MAT.
// Purely combinational; no handshake.
module dmw_match
    import mmu_xlate_pkg::*;
(
    input  logic [31:0] va_i,
    input  logic [31:0] dmw_i,
    input  logic [1:0]  plv_i,
    output logic        hit_o,
    output logic [31:0] pa_o,
    output logic [1:0]  mat_o
);
    logic plv_en;

    // Only PLV0 and PLV3 have enable bits; PLV1/2 can never use a window.
    always_comb begin
        plv_en = 1'b0;
        case (plv_i)
            2'd0:    plv_en = dmw_i[DMW_PLV0_BIT];
            2'd3:    plv_en = dmw_i[DMW_PLV3_BIT];
            default: plv_en = 1'b0;
        endcase
    end

    assign hit_o = plv_en && (va_i[31:29] == dmw_i[DMW_VSEG_LO +: 3]);
    assign pa_o  = {dmw_i[DMW_PSEG_LO +: 3], va_i[28:0]};
    assign mat_o = dmw_i[DMW_MAT_LO +: 2];

endmodule

// File: rtl/mmu_xlate.sv
// VA->PA translation (DA / DMW0 / DMW1 / TLB), response registered 1 cycle after accept.
// Backpressure: rsp held while !rsp_ready and no new accept; flush kills in-flight and same-cycle accept.
module mmu_xlate
    import mmu_xlate_pkg::*;
#(
    parameter int TLBNUM = XLATE_TLBNUM,
    parameter int PALEN  = 32
)(
    input  logic        clk,
    input  logic        resetn,
    mmu_xlate_if.slave  xif
);
    localparam int IDXW = $clog2(TLBNUM);

    logic             req_ready;
    logic             accept;
    logic             dmw0_hit, dmw1_hit;
    logic [31:0]      dmw0_pa, dmw1_pa;
    logic [1:0]       dmw0_mat, dmw1_mat;
    tlb_result_t      res;
    logic [31:0]      tlb_pa;

    logic             rsp_valid_q, rsp_valid_d;
    logic [PALEN-1:0] rsp_pa_q, rsp_pa_d;
    logic [1:0]       rsp_mat_q, rsp_mat_d;
    xlate_exc_t       rsp_exc_q, rsp_exc_d;
    logic [IDXW-1:0]  rsp_idx_q, rsp_idx_d;

    assign req_ready = !xif.flush && (!rsp_valid_q || xif.rsp_ready);
    assign accept    = xif.req_valid && req_ready;

    assign xif.req_ready      = req_ready;
    assign xif.tlb_s_valid    = accept;
    assign xif.tlb_s_vppn     = xif.req_va[31:13];
    assign xif.tlb_s_va_bit12 = xif.req_va[12];
    assign xif.tlb_s_asid     = xif.csr_asid;

    dmw_match u_dmw0 (
        .va_i  (xif.req_va),
        .dmw_i (xif.csr_dmw0),
        .plv_i (xif.csr_plv),
        .hit_o (dmw0_hit),
        .pa_o  (dmw0_pa),
        .mat_o (dmw0_mat)
    );

    dmw_match u_dmw1 (
        .va_i  (xif.req_va),
        .dmw_i (xif.csr_dmw1),
        .plv_i (xif.csr_plv),
        .hit_o (dmw1_hit),
        .pa_o  (dmw1_pa),
        .mat_o (dmw1_mat)
    );

    assign res    = xif.tlb_s_result;
    assign tlb_pa = (res.ps == 6'd12) ? {res.ppn, xif.req_va[11:0]}
                                      : {res.ppn[19:9], xif.req_va[20:0]};

    always_comb begin
        rsp_pa_d  = PALEN'(tlb_pa);
        rsp_mat_d = res.mat;
        rsp_exc_d = EXC_NONE;
        rsp_idx_d = IDXW'(res.index);
        if (xif.csr_da) begin
            rsp_pa_d  = PALEN'(xif.req_va);
            rsp_mat_d = xif.csr_da_mat;
            rsp_idx_d = '0;
        end else if (dmw0_hit) begin
            rsp_pa_d  = PALEN'(dmw0_pa);
            rsp_mat_d = dmw0_mat;
            rsp_idx_d = '0;
        end else if (dmw1_hit) begin
            rsp_pa_d  = PALEN'(dmw1_pa);
            rsp_mat_d = dmw1_mat;
            rsp_idx_d = '0;
        end else if (!res.found) begin
            // Refill: nothing meaningful to report from a miss.
            rsp_pa_d  = '0;
            rsp_mat_d = 2'd0;
            rsp_exc_d = EXC_TLBR;
            rsp_idx_d = '0;
        end else if (!res.v) begin
            rsp_exc_d = invalid_page_exc(xif.req_op);
        end else if (xif.csr_plv > res.plv) begin
            rsp_exc_d = EXC_PPI;
        end else if ((xif.req_op == XLATE_OP_STORE) && !res.d) begin
            rsp_exc_d = EXC_PME;
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        if (xif.flush)
            rsp_valid_d = 1'b0;
        else if (accept)
            rsp_valid_d = 1'b1;
        else if (xif.rsp_ready)
            rsp_valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rsp_valid_q <= 1'b0;
            rsp_pa_q    <= '0;
            rsp_mat_q   <= 2'd0;
            rsp_exc_q   <= EXC_NONE;
            rsp_idx_q   <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            if (accept) begin
                rsp_pa_q  <= rsp_pa_d;
                rsp_mat_q <= rsp_mat_d;
                rsp_exc_q <= rsp_exc_d;
                rsp_idx_q <= rsp_idx_d;
            end
        end
    end

    assign xif.rsp_valid     = rsp_valid_q;
    assign xif.rsp_pa        = rsp_pa_q;
    assign xif.rsp_mat       = rsp_mat_q;
    assign xif.rsp_exc       = rsp_exc_q;
    assign xif.rsp_tlb_index = rsp_idx_q;

endmodule
